// File: rtl/move_sequencer.sv
// move_sequencer: walks the 4x4 board one line at a time, feeding each line
// through an external combinational merge unit and writing the result back.
// Reports whether the move changed the board and whether the win tile appeared.
module move_sequencer #(
    parameter int CELL_W    = 12,
    parameter int WIN_VALUE = 256
) (
    input  logic                ClkPort,
    input  logic                Reset_bar,
    input  logic                mv_req,
    input  logic [1:0]          mv_dir,
    output logic                mv_busy,
    output logic                mv_ack,
    output logic                changed,
    output logic                win,
    output logic                spawn_req,
    output logic [3:0]          rd_addr,
    input  logic [CELL_W-1:0]   rd_data,
    output logic [4*CELL_W-1:0] ln_out,
    input  logic [4*CELL_W-1:0] ln_in,
    output logic                wr_en,
    output logic [3:0]          wr_addr,
    output logic [CELL_W-1:0]   wr_data
);

    localparam logic [CELL_W-1:0] WIN_CELL = CELL_W'(WIN_VALUE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MERGE,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [1:0]        line_reg;
    logic [1:0]        elem_reg;
    logic [1:0]        dir_reg;
    logic              changed_reg;
    logic              win_reg;
    logic [CELL_W-1:0] lbuf_reg [4];
    logic [CELL_W-1:0] rbuf_reg [4];
    logic [CELL_W-1:0] merged   [4];
    logic [3:0]        win_hit;
    logic              line_diff;
    logic [3:0]        cur_cell;
    logic              accept;

    // Board index of element k of line l; element 0 is the cell tiles slide toward.
    // 3-k on a 2-bit index is its bitwise complement.
    function automatic logic [3:0] cell_index(input logic [1:0] d,
                                              input logic [1:0] l,
                                              input logic [1:0] k);
        case (d)
            2'b00:   return {k, l};    // up
            2'b01:   return {~k, l};   // down
            2'b10:   return {l, k};    // left
            default: return {l, ~k};   // right
        endcase
    endfunction

    assign cur_cell  = cell_index(dir_reg, line_reg, elem_reg);
    assign accept    = (state_reg == ST_IDLE) && mv_req;
    assign line_diff = (ln_in != ln_out);
    assign changed   = changed_reg;
    assign win       = win_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_elem
            assign ln_out[gi*CELL_W +: CELL_W] = lbuf_reg[gi];
            assign merged[gi]  = ln_in[gi*CELL_W +: CELL_W];
            assign win_hit[gi] = (merged[gi] == WIN_CELL);

            // Capture element gi of the line being gathered.
            always_ff @(posedge ClkPort or negedge Reset_bar) begin
                if (!Reset_bar) begin
                    lbuf_reg[gi] <= '0;
                end else if (state_reg == ST_READ && elem_reg == 2'(gi)) begin
                    lbuf_reg[gi] <= rd_data;
                end
            end

            // Hold element gi of the merged line for the write-back pass.
            always_ff @(posedge ClkPort or negedge Reset_bar) begin
                if (!Reset_bar) begin
                    rbuf_reg[gi] <= '0;
                end else if (state_reg == ST_MERGE) begin
                    rbuf_reg[gi] <= merged[gi];
                end
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge ClkPort or negedge Reset_bar) begin
        if (!Reset_bar) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode: 4 reads, 1 merge, 4 writes per line, four lines.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (mv_req) state_next = ST_READ;
            ST_READ:  if (elem_reg == 2'd3) state_next = ST_MERGE;
            ST_MERGE: state_next = ST_WRITE;
            ST_WRITE: begin
                if (elem_reg == 2'd3) begin
                    state_next = (line_reg == 2'd3) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Line/element counters, latched direction and sticky move flags.
    // elem wraps 3->0 naturally, leaving it at 0 for the next phase.
    always_ff @(posedge ClkPort or negedge Reset_bar) begin
        if (!Reset_bar) begin
            line_reg    <= '0;
            elem_reg    <= '0;
            dir_reg     <= '0;
            changed_reg <= 1'b0;
            win_reg     <= 1'b0;
        end else if (accept) begin
            line_reg    <= '0;
            elem_reg    <= '0;
            dir_reg     <= mv_dir;
            changed_reg <= 1'b0;
            win_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_READ: elem_reg <= elem_reg + 2'd1;
                ST_MERGE: begin
                    changed_reg <= changed_reg | line_diff;
                    win_reg     <= win_reg | (|win_hit);
                end
                ST_WRITE: begin
                    elem_reg <= elem_reg + 2'd1;
                    if (elem_reg == 2'd3) line_reg <= line_reg + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Output decode: addresses and strobes are only non-zero in their own phase.
    always_comb begin
        mv_busy   = (state_reg != ST_IDLE);
        mv_ack    = 1'b0;
        spawn_req = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        case (state_reg)
            ST_READ:  rd_addr = cur_cell;
            ST_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = cur_cell;
                wr_data = rbuf_reg[elem_reg];
            end
            ST_DONE: begin
                mv_ack    = 1'b1;
                spawn_req = changed_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Testbench for move_sequencer: board memory and line-merge datapath modelled
// here, results compared against a whole-board reference move.
module tb_move_sequencer;

    localparam int CW = 12;

    logic              ClkPort;
    logic              Reset_bar;
    logic              mv_req;
    logic [1:0]        mv_dir;
    logic              mv_busy;
    logic              mv_ack;
    logic              changed;
    logic              win;
    logic              spawn_req;
    logic [3:0]        rd_addr;
    logic [CW-1:0]     rd_data;
    logic [4*CW-1:0]   ln_out;
    logic [4*CW-1:0]   ln_in;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [CW-1:0]     wr_data;

    logic [15:0][CW-1:0] board;
    logic [15:0][CW-1:0] exp_board;
    logic [15:0][CW-1:0] load_vals;
    logic [15:0][CW-1:0] v;
    logic                load_en;
    logic                exp_changed;
    logic                exp_win;

    int n_checks = 0;
    int n_fail   = 0;

    // per-move observation log
    int         busy_cnt, busy_first, busy_last;
    int         ack_cnt, ack_cyc, spawn_cnt, spawn_cyc, wr_cnt;
    logic       chg_ack, win_ack;
    logic [CW-1:0] cell0_at10;
    logic [3:0] rd_log [41];
    logic [3:0] wr_log [32];
    int         wr_cyc [32];

    move_sequencer #(.CELL_W(CW), .WIN_VALUE(256)) dut (
        .ClkPort   (ClkPort),
        .Reset_bar (Reset_bar),
        .mv_req    (mv_req),
        .mv_dir    (mv_dir),
        .mv_busy   (mv_busy),
        .mv_ack    (mv_ack),
        .changed   (changed),
        .win       (win),
        .spawn_req (spawn_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .ln_out    (ln_out),
        .ln_in     (ln_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial ClkPort = 1'b0;
    always #5 ClkPort = ~ClkPort;

    // 2048 slide-and-merge of one line toward e0, each tile merges at most once.
    function automatic logic [4*CW-1:0] merge_line(input logic [4*CW-1:0] ln);
        int vals [4];
        int outv [4];
        int n;
        int pend;
        logic [4*CW-1:0] r;
        for (int i = 0; i < 4; i++) begin
            vals[i] = int'(ln[i*CW +: CW]);
            outv[i] = 0;
        end
        n = 0;
        pend = 0;
        for (int i = 0; i < 4; i++) begin
            if (vals[i] != 0) begin
                if (pend != 0 && pend == vals[i]) begin
                    outv[n] = 2 * vals[i];
                    n++;
                    pend = 0;
                end else begin
                    if (pend != 0) begin
                        outv[n] = pend;
                        n++;
                    end
                    pend = vals[i];
                end
            end
        end
        if (pend != 0) outv[n] = pend;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*CW +: CW] = CW'(outv[i]);
        return r;
    endfunction

    assign ln_in   = merge_line(ln_out);
    assign rd_data = board[rd_addr];

    always @(posedge ClkPort) begin
        if (load_en)    board <= load_vals;
        else if (wr_en) board[wr_addr] <= wr_data;
    end

    function automatic int cidx(input int d, input int l, input int k);
        case (d)
            0:       return k * 4 + l;
            1:       return (3 - k) * 4 + l;
            2:       return l * 4 + k;
            default: return l * 4 + (3 - k);
        endcase
    endfunction

    // Reference: whole move on the current board snapshot.
    task automatic model_move(input int d);
        logic [4*CW-1:0] g, m;
        exp_changed = 1'b0;
        exp_win     = 1'b0;
        for (int l = 0; l < 4; l++) begin
            g = '0;
            for (int k = 0; k < 4; k++) g[k*CW +: CW] = board[cidx(d, l, k)];
            m = merge_line(g);
            for (int k = 0; k < 4; k++) exp_board[cidx(d, l, k)] = m[k*CW +: CW];
        end
        for (int i = 0; i < 16; i++) begin
            if (exp_board[i] != board[i]) exp_changed = 1'b1;
            if (exp_board[i] == CW'(256)) exp_win = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".mv_busy"},   mv_busy,   0);
        check({tag, ".mv_ack"},    mv_ack,    0);
        check({tag, ".changed"},   changed,   0);
        check({tag, ".win"},       win,       0);
        check({tag, ".spawn_req"}, spawn_req, 0);
        check({tag, ".wr_en"},     wr_en,     0);
        check({tag, ".rd_addr"},   rd_addr,   0);
        check({tag, ".wr_addr"},   wr_addr,   0);
        check({tag, ".wr_data"},   wr_data,   0);
        check({tag, ".ln_out"},    ln_out,    0);
    endtask

    task automatic load(input logic [15:0][CW-1:0] vals);
        @(negedge ClkPort);
        load_vals = vals;
        load_en   = 1'b1;
        @(negedge ClkPort);
        load_en   = 1'b0;
    endtask

    // Issue one move and log 40 cycles after the accept cycle T (cycle c = T+c).
    task automatic run_move(input logic [1:0] d, input bit mid_req);
        busy_cnt = 0; busy_first = 0; busy_last = 0;
        ack_cnt = 0; ack_cyc = 0; spawn_cnt = 0; spawn_cyc = 0; wr_cnt = 0;
        chg_ack = 1'b0; win_ack = 1'b0; cell0_at10 = '0;
        @(negedge ClkPort);
        mv_req = 1'b1;
        mv_dir = d;
        @(posedge ClkPort);
        #1 mv_req = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge ClkPort);
            if (mid_req && c == 10) begin
                mv_req = 1'b1;
                mv_dir = ~d;
            end
            if (mid_req && c == 11) mv_req = 1'b0;
            rd_log[c] = rd_addr;
            if (c == 10) cell0_at10 = board[0];
            if (mv_busy) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = c;
                busy_last = c;
            end
            if (mv_ack) begin
                ack_cnt++;
                ack_cyc = c;
                chg_ack = changed;
                win_ack = win;
            end
            if (spawn_req) begin
                spawn_cnt++;
                spawn_cyc = c;
            end
            if (wr_en && wr_cnt < 32) begin
                wr_log[wr_cnt] = wr_addr;
                wr_cyc[wr_cnt] = c;
                wr_cnt++;
            end
        end
        $display("move dir=%0d changed=%0b win=%0b ack_cycle=%0d writes=%0d", d, chg_ack, win_ack, ack_cyc, wr_cnt);
    endtask

    initial begin
        Reset_bar = 1'b0;
        mv_req    = 1'b0;
        mv_dir    = 2'b00;
        load_en   = 1'b0;
        load_vals = '0;
        repeat (2) @(posedge ClkPort);
        @(negedge ClkPort);
        check_idle_outputs("reset");
        Reset_bar = 1'b1;
        @(negedge ClkPort);

        // Left, row0 = [2,2,0,0]
        v = '0; v[0] = 2; v[1] = 2;
        load(v);
        model_move(2);
        run_move(2'b10, 1'b0);
        check("left.board",      board, exp_board);
        check("left.cell0_T10",  cell0_at10, 4);
        check("left.cell1",      board[1], 0);
        check("left.changed",    chg_ack, 1);
        check("left.spawn_cnt",  spawn_cnt, 1);
        check("left.spawn_cyc",  spawn_cyc, 37);
        check("left.ack_cnt",    ack_cnt, 1);
        check("left.ack_cyc",    ack_cyc, 37);
        check("left.busy_width", busy_cnt, 37);
        check("left.busy_first", busy_first, 1);
        check("left.busy_last",  busy_last, 37);
        check("left.wr_cnt",     wr_cnt, 16);
        check("left.wr_first",   wr_cyc[0], 6);
        check("left.wr_last",    wr_cyc[15], 36);
        check("left.wr_line1",   wr_cyc[4], 15);
        check("left.changed_hold", changed, 1);

        // Down, column 1 read/write order
        v = '0; v[1] = 2; v[9] = 2; v[13] = 4; v[3] = 8;
        load(v);
        model_move(1);
        run_move(2'b01, 1'b0);
        check("down.rd_order", {rd_log[10], rd_log[11], rd_log[12], rd_log[13]}, {4'd13, 4'd9, 4'd5, 4'd1});
        check("down.wr_order", {wr_log[4], wr_log[5], wr_log[6], wr_log[7]}, {4'd13, 4'd9, 4'd5, 4'd1});
        check("down.board",    board, exp_board);
        check("down.cell13",   board[13], 4);
        check("down.cell9",    board[9], 4);

        // Right on a board already packed right, no equal neighbours
        v = '0;
        v[1] = 2; v[2] = 4; v[3] = 8;
        v[4] = 2; v[5] = 4; v[6] = 8; v[7] = 16;
        v[11] = 4;
        load(v);
        run_move(2'b11, 1'b0);
        check("right.board",   board, v);
        check("right.wr_cnt",  wr_cnt, 16);
        check("right.changed", chg_ack, 0);
        check("right.ack_cnt", ack_cnt, 1);
        check("right.spawn",   spawn_cnt, 0);

        // Up, column 0 = [128,128,0,0] produces the win tile
        v = '0; v[0] = 128; v[4] = 128;
        load(v);
        model_move(0);
        run_move(2'b00, 1'b0);
        check("up.cell0",   board[0], 256);
        check("up.board",   board, exp_board);
        check("up.win",     win_ack, 1);
        check("up.changed", chg_ack, 1);
        check("up.win_hold", win, 1);

        // Request mid-move with another direction is ignored
        v = '0; v[0] = 2; v[1] = 2; v[12] = 8;
        load(v);
        model_move(2);
        run_move(2'b10, 1'b1);
        check("midreq.ack_cnt", ack_cnt, 1);
        check("midreq.ack_cyc", ack_cyc, 37);
        check("midreq.busy",    busy_cnt, 37);
        check("midreq.board",   board, exp_board);

        // Reset in the middle of a move
        v = '0; v[0] = 4; v[3] = 4; v[5] = 2; v[6] = 2;
        load(v);
        @(negedge ClkPort);
        mv_req = 1'b1;
        mv_dir = 2'b11;
        @(posedge ClkPort);
        #1 mv_req = 1'b0;
        repeat (20) @(negedge ClkPort);
        check("midrst.busy_before", mv_busy, 1);
        Reset_bar = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (2) @(negedge ClkPort);
        Reset_bar = 1'b1;
        repeat (5) @(negedge ClkPort);
        check("midrst.stay_idle", {mv_busy, mv_ack, wr_en, rd_addr}, 0);
        model_move(3);
        run_move(2'b11, 1'b0);
        check("midrst.ack_cyc", ack_cyc, 37);
        check("midrst.board",   board, exp_board);

        // Randomised boards and directions
        for (int t = 0; t < 8; t++) begin
            logic [1:0] d;
            for (int i = 0; i < 16; i++) begin
                int r;
                r = int'($urandom_range(0, 8));
                v[i] = (r == 0) ? CW'(0) : CW'(1 << r);
            end
            d = 2'($urandom_range(0, 3));
            load(v);
            model_move(int'(d));
            run_move(d, 1'b0);
            check("rand.board",   board, exp_board);
            check("rand.changed", chg_ack, exp_changed);
            check("rand.win",     win_ack, exp_win);
            check("rand.spawn",   spawn_cnt, exp_changed ? 1 : 0);
            check("rand.ack_cyc", ack_cyc, 37);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
